// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Pipeline sequencing controller for a 5-stage RISC-V core.
//             Inserts a load-use bubble, freezes the pipe during multi-cycle
//             data-memory accesses, flushes on taken branch/jump redirects,
//             guards memory waits with a timeout and keeps saturating
//             stall/flush performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  use_rs1_id,
   input  logic                  use_rs2_id,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  mem_read_ex,
   input  logic                  branch_taken_ex,
   input  logic                  dmem_req_mem,
   input  logic                  dmem_ready,
   input  logic                  cnt_clr,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  ex_mem_write,
   output logic                  id_ex_bubble,
   output logic                  if_id_flush,
   output logic                  mem_wb_bubble,
   output logic                  mem_err,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_count
);

   // Wait counter must be able to hold the value MEM_TIMEOUT itself.
   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] C_TIMEOUT = WCNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic [CNT_W-1:0]  flush_q, flush_d;

   logic freeze;
   logic load_use;
   logic redirect;
   logic lu_stall;

   // Hazard detection: freeze dominates, then redirect, then load-use.
   always_comb begin
      freeze   = ((state_q == S_RUN)  & dmem_req_mem & ~dmem_ready) |
                 ((state_q == S_WAIT) & ~dmem_ready) |
                 (state_q == S_ERR);
      load_use = mem_read_ex & (rd_ex != '0) &
                 ((use_rs1_id & (rs1_id == rd_ex)) |
                  (use_rs2_id & (rs2_id == rd_ex)));
      redirect = branch_taken_ex & ~freeze;
      lu_stall = load_use & ~freeze & ~branch_taken_ex;
   end

   // Stage-register controls derived from the resolved hazard.
   always_comb begin
      pc_write      = ~freeze & ~lu_stall;
      if_id_write   = ~freeze & ~lu_stall;
      id_ex_write   = ~freeze;
      ex_mem_write  = ~freeze;
      id_ex_bubble  = ~freeze & (branch_taken_ex | load_use);
      if_id_flush   = redirect;
      mem_wb_bubble = freeze;
   end

   // Memory-wait sequencing: RUN -> WAIT on a stalled access, ERR on timeout.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         S_RUN: begin
            if (dmem_req_mem && !dmem_ready) begin
               state_d    = S_WAIT;
               wait_cnt_d = WCNT_W'(1);
            end
         end
         S_WAIT: begin
            if (dmem_ready) begin
               state_d    = S_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == C_TIMEOUT) begin
               state_d   = S_ERR;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
         end
         S_ERR: begin
            // Absorbing until reset; dmem_ready is deliberately ignored.
            state_d = S_ERR;
         end
         default: begin
            state_d    = S_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Saturating performance counters; clear wins over increment.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (cnt_clr) begin
         stall_d = '0;
         flush_d = '0;
      end else begin
         if ((freeze || load_use) && (stall_q != C_CNT_MAX))
            stall_d = stall_q + CNT_W'(1);
         if (redirect && (flush_q != C_CNT_MAX))
            flush_d = flush_q + CNT_W'(1);
      end
   end

   // State registers with immediate reset.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= S_RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
         stall_q    <= '0;
         flush_q    <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
         stall_q    <= stall_d;
         flush_q    <= flush_d;
      end
   end

   assign mem_err      = mem_err_q;
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Directed self-checking bench for hazard_ctrl (CNT_W=4,
//             MEM_TIMEOUT=4 so saturation and timeout are reachable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   logic       clk;
   logic       arst_n;
   logic [4:0] rs1_id, rs2_id, rd_ex;
   logic       use_rs1_id, use_rs2_id, mem_read_ex, branch_taken_ex;
   logic       dmem_req_mem, dmem_ready, cnt_clr;
   logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
   logic       id_ex_bubble, if_id_flush, mem_wb_bubble, mem_err;
   logic [3:0] stall_cycles, flush_count;

   int errors = 0;
   int checks = 0;

   hazard_ctrl #(
      .REG_ADDR_W (5),
      .CNT_W      (4),
      .MEM_TIMEOUT(4)
   ) dut (
      .clk            (clk),
      .arst_n         (arst_n),
      .rs1_id         (rs1_id),
      .rs2_id         (rs2_id),
      .use_rs1_id     (use_rs1_id),
      .use_rs2_id     (use_rs2_id),
      .rd_ex          (rd_ex),
      .mem_read_ex    (mem_read_ex),
      .branch_taken_ex(branch_taken_ex),
      .dmem_req_mem   (dmem_req_mem),
      .dmem_ready     (dmem_ready),
      .cnt_clr        (cnt_clr),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .id_ex_write    (id_ex_write),
      .ex_mem_write   (ex_mem_write),
      .id_ex_bubble   (id_ex_bubble),
      .if_id_flush    (if_id_flush),
      .mem_wb_bubble  (mem_wb_bubble),
      .mem_err        (mem_err),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1_id = '0; rs2_id = '0; rd_ex = '0;
      use_rs1_id = 0; use_rs2_id = 0; mem_read_ex = 0; branch_taken_ex = 0;
      dmem_req_mem = 0; dmem_ready = 0; cnt_clr = 0;
   endtask

   task automatic set_load_use();
      mem_read_ex = 1; rd_ex = 5'd5; rs2_id = 5'd5; use_rs2_id = 1;
   endtask

   initial begin
      idle();
      arst_n = 1'b0;
      #23;
      arst_n = 1'b1;
      tick();

      // Reset / idle
      #1;
      chk("rst_pc_write",     pc_write,      1);
      chk("rst_if_id_write",  if_id_write,   1);
      chk("rst_id_ex_write",  id_ex_write,   1);
      chk("rst_ex_mem_write", ex_mem_write,  1);
      chk("rst_id_ex_bubble", id_ex_bubble,  0);
      chk("rst_if_id_flush",  if_id_flush,   0);
      chk("rst_mem_wb_bub",   mem_wb_bubble, 0);
      chk("rst_mem_err",      mem_err,       0);
      chk("rst_stall",        stall_cycles,  0);
      chk("rst_flush",        flush_count,   0);

      // Load-use on rs2
      tick();
      set_load_use();
      #1;
      chk("lu_pc_write",    pc_write,     0);
      chk("lu_if_id_write", if_id_write,  0);
      chk("lu_bubble",      id_ex_bubble, 1);
      chk("lu_id_ex_write", id_ex_write,  1);
      tick();
      idle();
      #1;
      chk("lu_released",    pc_write,     1);
      chk("lu_stall_cnt",   stall_cycles, 1);
      // rd_ex==0 never stalls
      mem_read_ex = 1; rd_ex = 5'd0; rs2_id = 5'd0; use_rs2_id = 1;
      #1;
      chk("lu_x0_pc_write", pc_write,     1);
      chk("lu_x0_bubble",   id_ex_bubble, 0);
      tick();
      // matching rs1 that is not read does not stall
      idle();
      mem_read_ex = 1; rd_ex = 5'd7; rs1_id = 5'd7; use_rs1_id = 0;
      #1;
      chk("lu_unused_pc",   pc_write,     1);
      tick();
      idle();
      #1;
      chk("lu_no_extra",    stall_cycles, 1);

      // Multi-cycle memory access: 3 frozen cycles then ready
      dmem_req_mem = 1; dmem_ready = 0;
      #1;
      chk("frz0_pc_write",  pc_write,      0);
      chk("frz0_ex_mem_wr", ex_mem_write,  0);
      chk("frz0_mem_wb",    mem_wb_bubble, 1);
      tick();
      chk("frz1_id_ex_wr",  id_ex_write,   0);
      tick();
      chk("frz2_if_id_wr",  if_id_write,   0);
      tick();
      dmem_ready = 1;
      #1;
      chk("rdy_pc_write",   pc_write,      1);
      chk("rdy_mem_wb",     mem_wb_bubble, 0);
      chk("rdy_stall_cnt",  stall_cycles,  4);
      tick();
      idle();
      #1;
      chk("back_run_pc",    pc_write,      1);
      chk("back_run_stall", stall_cycles,  4);

      // Redirect together with load-use: redirect wins
      branch_taken_ex = 1;
      set_load_use();
      #1;
      chk("br_flush",       if_id_flush,   1);
      chk("br_bubble",      id_ex_bubble,  1);
      chk("br_pc_write",    pc_write,      1);
      chk("br_if_id_write", if_id_write,   1);
      tick();
      idle();
      #1;
      chk("br_flush_cnt",   flush_count,   1);

      // Branch held during WAIT acts only on release
      dmem_req_mem = 1; branch_taken_ex = 1;
      #1;
      chk("brw0_flush",     if_id_flush,   0);
      chk("brw0_pc",        pc_write,      0);
      tick();
      chk("brw1_flush",     if_id_flush,   0);
      tick();
      dmem_ready = 1;
      #1;
      chk("brw_rel_flush",  if_id_flush,   1);
      chk("brw_rel_pc",     pc_write,      1);
      tick();
      idle();
      #1;
      chk("brw_flush_cnt",  flush_count,   2);

      // Stall counter saturation
      set_load_use();
      for (int i = 0; i < 20; i++) tick();
      idle();
      #1;
      chk("stall_sat",      stall_cycles,  15);
      // Clear concurrent with a stall
      set_load_use();
      cnt_clr = 1;
      tick();
      idle();
      #1;
      chk("clr_stall",      stall_cycles,  0);
      chk("clr_flush",      flush_count,   0);

      // Memory timeout: RUN frozen cycle, then WAIT cnt 1..4, then ERR
      dmem_req_mem = 1; dmem_ready = 0;
      tick();   // WAIT cnt=1
      tick();   // cnt=2
      tick();   // cnt=3
      tick();   // cnt=4
      #1;
      chk("to_pre_err",     mem_err,       0);
      tick();   // ERR
      #1;
      chk("to_err",         mem_err,       1);
      chk("to_err_pc",      pc_write,      0);
      dmem_req_mem = 0; dmem_ready = 1;
      #1;
      chk("err_ignore_rdy", mem_wb_bubble, 1);
      tick();
      #1;
      chk("err_sticky",     mem_err,       1);
      chk("err_frozen",     pc_write,      0);

      // Asynchronous reset in the middle of a cycle
      #2;
      arst_n = 1'b0;
      #1;
      chk("arst_mem_err",   mem_err,       0);
      chk("arst_pc_write",  pc_write,      1);
      chk("arst_stall",     stall_cycles,  0);
      #1;
      arst_n = 1'b1;
      idle();
      tick();
      #1;
      chk("post_rst_run",   mem_wb_bubble, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
